// File: rtl/reg_wb_target_pkg.sv
// reg_wb_target_pkg: shared bus constants, register map and helper functions
package reg_wb_target_pkg;
  localparam int SYS_CLOCK_MHZ = 64;
  localparam int WB_ADDR_WIDTH = 20;
  localparam int DATA_WIDTH = 8;
  localparam logic [2:0] WB_REG_PREFIX = 3'b010;
  localparam int REG_ADDR_WIDTH = 1;
  localparam int REG_COUNT = 1;
  localparam logic [REG_ADDR_WIDTH-1:0] REG_CPU = '0;
  localparam int REG_CPU_READY_BIT = 0;
  localparam int REG_CPU_RESET_BIT = 1;
  localparam int REG_CPU_RESET_ACTIVE_BIT = 2;
  localparam int RESET_HOLD_NS_DEF = 1000;
  typedef struct packed {
    logic ready;
    logic reset;
  } reg_cpu_t;
  function automatic int ns_to_cycles(input int ns);
    return ns * SYS_CLOCK_MHZ / 1000;
  endfunction
  function automatic int bit_width(input int v);
    return $clog2(v + 1);
  endfunction
endpackage

// File: rtl/reg_wb_target_reset_stretch.sv
// reset_stretch: holds out high while trig is set and for CYCLES cycles after it clears
module reset_stretch #(
  parameter int CYCLES = 64,
  parameter int WIDTH = $clog2(CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  output logic out
);
  logic [WIDTH-1:0] cnt;
  // reload while triggered, otherwise count down to zero and stop there
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= WIDTH'(CYCLES);
      out <= 1'b1;
    end else begin
      cnt <= trig ? WIDTH'(CYCLES) : (cnt != '0) ? cnt - WIDTH'(1) : cnt;
      out <= trig | (cnt != '0);
    end
endmodule

// File: rtl/reg_wb_target.sv
// reg_wb_target: Wishbone register target hosting the CPU ready/reset control register
module reg_wb_target
  import reg_wb_target_pkg::*;
#(
  parameter int RESET_HOLD_NS = RESET_HOLD_NS_DEF,
  parameter int HOLD_WIDTH = bit_width(ns_to_cycles(RESET_HOLD_NS))
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic [WB_ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [DATA_WIDTH-1:0]    wb_dat_i,
  output logic [DATA_WIDTH-1:0]    wb_dat_o,
  input  logic                     wb_we_i,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  output logic                     wb_stall_o,
  output logic                     wb_ack_o,
  output logic                     cpu_ready_o,
  output logic                     cpu_reset_o
);
  localparam int HOLD_CYCLES = ns_to_cycles(RESET_HOLD_NS);
  reg_cpu_t cpu;
  logic ack_q;
  logic accept;
  logic cpu_hit;
  logic [DATA_WIDTH-1:0] rd_data;
  logic unused_bits;
  assign unused_bits = ^{wb_adr_i[16:REG_ADDR_WIDTH], wb_dat_i[DATA_WIDTH-1:2]};
  // decode and read mux; upper index bits are don't-care so the region aliases
  always_comb begin
    accept = wb_cyc_i & wb_stb_i & (wb_adr_i[19:17] == WB_REG_PREFIX);
    cpu_hit = wb_adr_i[REG_ADDR_WIDTH-1:0] == REG_CPU;
    rd_data = cpu_hit ? {5'b0, cpu_reset_o, cpu.reset, cpu.ready} : '0;
  end
  // register file, ack and read data all update on the accept edge
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) begin
      cpu <= '{ready: 1'b0, reset: 1'b1};
      ack_q <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      ack_q <= accept;
      if (accept) wb_dat_o <= rd_data;
      if (accept & wb_we_i & cpu_hit)
        cpu <= '{ready: wb_dat_i[REG_CPU_READY_BIT], reset: wb_dat_i[REG_CPU_RESET_BIT]};
    end
  reset_stretch #(.CYCLES(HOLD_CYCLES), .WIDTH(HOLD_WIDTH)) u_stretch (
    .clk(clock_i),
    .rst(reset_i),
    .trig(cpu.reset),
    .out(cpu_reset_o)
  );
  assign wb_ack_o = ack_q & wb_cyc_i;
  assign wb_stall_o = 1'b0;
  assign cpu_ready_o = cpu.ready & ~cpu_reset_o;
endmodule

// File: tb/tb_reg_wb_target.sv
// tb_reg_wb_target: directed vector table plus hand sequences for timing corners
module tb_reg_wb_target;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [19:0] adr = '0;
  logic [7:0] wdat = '0;
  logic [7:0] rdat;
  logic we = 1'b0, cyc = 1'b0, stb = 1'b0;
  logic stall, ack, rdy_o, rst_o;
  int ncmp = 0, nbad = 0;

  reg_wb_target dut (
    .clock_i(clk), .reset_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(rdat),
    .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_stall_o(stall), .wb_ack_o(ack),
    .cpu_ready_o(rdy_o), .cpu_reset_o(rst_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] adr;
    logic        we;
    logic [7:0]  wdat;
    logic        ack;
    logic        chk_dat;
    logic [7:0]  rdat;
    logic        rst_o;
    logic        rdy_o;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic [19:0] a, input logic w, input logic [7:0] d,
                      output logic got_ack, output logic [7:0] got_dat);
    adr = a; we = w; wdat = d; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0;
    got_ack = ack;
    got_dat = rdat;
    cyc = 1'b0; we = 1'b0;
  endtask

  task automatic count_fall(input int start, output int k);
    k = start - 1;
    do begin
      @(posedge clk); #1;
      k++;
    end while (rst_o && k < start + 300);
  endtask

  vec_t vt[14];
  logic a;
  logic [7:0] d;
  int k;
  int dropped;

  initial begin
    vt[0]  = '{20'h40000, 1'b0, 8'h00, 1'b1, 1'b1, 8'h06, 1'b1, 1'b0};
    vt[1]  = '{20'h5FFFF, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
    vt[2]  = '{20'h5FFFF, 1'b1, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[3]  = '{20'h40000, 1'b0, 8'h00, 1'b1, 1'b1, 8'h06, 1'b1, 1'b0};
    vt[4]  = '{20'h00010, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[5]  = '{20'h00010, 1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[6]  = '{20'h40000, 1'b0, 8'h00, 1'b1, 1'b1, 8'h06, 1'b1, 1'b0};
    vt[7]  = '{20'h60000, 1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[8]  = '{20'h40000, 1'b1, 8'hFE, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[9]  = '{20'h40000, 1'b0, 8'h00, 1'b1, 1'b1, 8'h06, 1'b1, 1'b0};
    vt[10] = '{20'h40000, 1'b1, 8'h03, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[11] = '{20'h40000, 1'b0, 8'h00, 1'b1, 1'b1, 8'h07, 1'b1, 1'b0};
    vt[12] = '{20'h4FFFE, 1'b1, 8'h02, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[13] = '{20'h40000, 1'b0, 8'h00, 1'b1, 1'b1, 8'h06, 1'b1, 1'b0};

    // asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    chk("rst_cpu_reset", rst_o, 1'b1);
    chk("rst_cpu_ready", rdy_o, 1'b0);
    chk("rst_ack", ack, 1'b0);
    chk("rst_stall", stall, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // register table
    for (int i = 0; i < 14; i++) begin
      xfer(vt[i].adr, vt[i].we, vt[i].wdat, a, d);
      chk($sformatf("vec%0d_ack", i), a, vt[i].ack);
      if (vt[i].chk_dat) chk($sformatf("vec%0d_dat", i), d, vt[i].rdat);
      chk($sformatf("vec%0d_cpu_reset", i), rst_o, vt[i].rst_o);
      chk($sformatf("vec%0d_cpu_ready", i), rdy_o, vt[i].rdy_o);
    end

    // back-to-back W00, R, W01, R with reset_bit set beforehand
    adr = 20'h40000; cyc = 1'b1; stb = 1'b1; we = 1'b1; wdat = 8'h00;
    @(posedge clk); #1;
    chk("b2b_ack0", ack, 1'b1);
    we = 1'b0;
    @(posedge clk); #1;
    chk("b2b_ack1", ack, 1'b1);
    chk("b2b_rd1", rdat, 8'h04);
    we = 1'b1; wdat = 8'h01;
    @(posedge clk); #1;
    chk("b2b_ack2", ack, 1'b1);
    we = 1'b0;
    @(posedge clk); #1;
    chk("b2b_ack3", ack, 1'b1);
    chk("b2b_rd3", rdat, 8'h05);
    stb = 1'b0; cyc = 1'b0;
    count_fall(1, k);
    chk("b2b_released", rst_o, 1'b0);
    chk("b2b_ready", rdy_o, 1'b1);

    // release timing from a single write of 8'h01
    xfer(20'h40000, 1'b1, 8'h02, a, d);
    @(posedge clk); @(posedge clk); #1;
    chk("hold_reasserted", rst_o, 1'b1);
    xfer(20'h40000, 1'b1, 8'h01, a, d);
    chk("rel_ack", a, 1'b1);
    xfer(20'h40000, 1'b0, 8'h00, a, d);
    chk("rel_rd_during", d, 8'h05);
    chk("rel_ready_during", rdy_o, 1'b0);
    count_fall(2, k);
    chk("rel_edges", k, 65);
    chk("rel_ready_after", rdy_o, 1'b1);
    xfer(20'h40000, 1'b0, 8'h00, a, d);
    chk("rel_rd_after", d, 8'h01);

    // reload mid-countdown
    xfer(20'h40000, 1'b1, 8'h02, a, d);
    xfer(20'h40000, 1'b1, 8'h00, a, d);
    dropped = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (!rst_o) dropped++;
    end
    xfer(20'h40000, 1'b1, 8'h02, a, d);
    if (!rst_o) dropped++;
    @(posedge clk); #1;
    if (!rst_o) dropped++;
    xfer(20'h40000, 1'b1, 8'h00, a, d);
    if (!rst_o) dropped++;
    chk("reload_no_drop", dropped, 0);
    count_fall(1, k);
    chk("reload_edges", k, 65);

    // cycle abort in the ack cycle
    adr = 20'h40000; we = 1'b1; wdat = 8'h01; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    #1;
    chk("abort_ack", ack, 1'b0);
    @(posedge clk); #1;
    chk("abort_ready", rdy_o, 1'b1);
    xfer(20'h40000, 1'b0, 8'h00, a, d);
    chk("abort_rd", d, 8'h01);

    // async reset mid-countdown with an ack in flight
    xfer(20'h40000, 1'b1, 8'h02, a, d);
    xfer(20'h40000, 1'b1, 8'h01, a, d);
    repeat (10) @(posedge clk);
    #1;
    adr = 20'h40000; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    chk("inflight_ack", ack, 1'b1);
    stb = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_ack", ack, 1'b0);
    chk("midrst_cpu_reset", rst_o, 1'b1);
    chk("midrst_cpu_ready", rdy_o, 1'b0);
    cyc = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    xfer(20'h40000, 1'b0, 8'h00, a, d);
    chk("post_rst_ack", a, 1'b1);
    chk("post_rst_rd", d, 8'h06);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
